// File: rtl/imem_load_arbiter.sv
// -----------------------------------------------------------------------------
// imem_load_arbiter
//
// Purpose:
//   Owns the single-port synchronous instruction memory and shares it between
//   the core fetch stage (reads) and a burst instruction loader (writes coming
//   from the host/network side). The memory has a one-cycle read latency and a
//   write cycle does not update its read data.
//
//   A burst is started in IDLE with a base address and a word count. While the
//   burst runs, every cycle either one write or one fetch is granted, never
//   both. Writes win while fetch is idle. When fetch is waiting, at most
//   max_run_p consecutive writes are granted before fetch gets a turn, so a
//   load can never starve the core.
//
// Parameters:
//   addr_width_p  memory address width, depth = 2**addr_width_p
//   max_run_p     max consecutive writes granted while fetch is pending (>= 1)
//
// Ports:
//   clk                 clock
//   reset_n             asynchronous active-low reset
//   load_start_i        burst start request, only looked at in IDLE
//   load_addr_i         burst base address
//   load_len_i          burst length in words, 0 .. 2**addr_width_p
//   load_valid_i        load_data_i holds a word to write
//   load_data_i         instruction word to write
//   load_ready_o        write accepted this cycle
//   load_busy_o         burst in progress (registered)
//   load_done_o         one-cycle pulse after a burst completes (registered)
//   fetch_valid_i       fetch read request
//   fetch_addr_i        fetch address
//   fetch_ready_o       fetch accepted this cycle
//   fetch_data_o        read data, pass-through of mem_instr_i
//   fetch_data_valid_o  fetch_data_o valid, the cycle after acceptance
//   mem_addr_o          memory address
//   mem_instr_o         memory write data
//   mem_wen_o           memory write enable
//   mem_instr_i         memory read data
// -----------------------------------------------------------------------------

package imem_load_arbiter_pkg;

    // One instruction word as stored in the instruction memory.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [24:0] operands;
    } instruction_s;

endpackage

module imem_load_arbiter
    import imem_load_arbiter_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int max_run_p    = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    load_start_i,
    input  logic [addr_width_p-1:0] load_addr_i,
    input  logic [addr_width_p:0]   load_len_i,
    input  logic                    load_valid_i,
    input  instruction_s            load_data_i,
    output logic                    load_ready_o,
    output logic                    load_busy_o,
    output logic                    load_done_o,

    input  logic                    fetch_valid_i,
    input  logic [addr_width_p-1:0] fetch_addr_i,
    output logic                    fetch_ready_o,
    output instruction_s            fetch_data_o,
    output logic                    fetch_data_valid_o,

    output logic [addr_width_p-1:0] mem_addr_o,
    output instruction_s            mem_instr_o,
    output logic                    mem_wen_o,
    input  instruction_s            mem_instr_i
);

    localparam int AW   = addr_width_p;
    localparam int LW   = addr_width_p + 1;
    localparam int RunW = (max_run_p < 1) ? 1 : $clog2(max_run_p + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(max_run_p);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e            r_state;
    logic [AW-1:0]     r_cur_addr;
    logic [LW-1:0]     r_remaining;
    logic [RunW-1:0]   r_run_cnt;
    logic              r_load_busy;
    logic              r_load_done;
    logic              r_fetch_data_valid;

    logic              w_write_grant;
    logic              w_fetch_grant;
    logic              w_last_write;
    logic              w_len_zero;
    logic [RunW-1:0]   w_run_cnt_next;

    // Grant decision for the current cycle. In IDLE the loader never writes
    // and every fetch request is accepted. In LOAD a pending write wins unless
    // fetch is waiting and the current write run has already hit max_run_p.
    // These grants are not gated by reset; the outputs below are, and the
    // state register ignores them while reset is held.
    always_comb begin
        w_write_grant = 1'b0;
        w_fetch_grant = 1'b0;
        if (r_state == IDLE) begin
            w_fetch_grant = fetch_valid_i;
        end else begin
            w_write_grant = load_valid_i && (!fetch_valid_i || (r_run_cnt < RunMax));
            w_fetch_grant = fetch_valid_i && !w_write_grant;
        end
    end

    // The write run only grows while fetch is actually waiting; a write with
    // no fetch pending restarts the run so fetch always gets a full window
    // when it arrives. The saturation guard is defensive: a granted write
    // with fetch pending always sees r_run_cnt below the limit.
    always_comb begin
        w_run_cnt_next = '0;
        if (fetch_valid_i) begin
            if (r_run_cnt == RunMax) begin
                w_run_cnt_next = RunMax;
            end else begin
                w_run_cnt_next = r_run_cnt + RunW'(1);
            end
        end
    end

    assign w_last_write = (r_remaining == LW'(1));
    assign w_len_zero   = (load_len_i == '0);

    // Handshake and memory-control outputs are forced low during reset so the
    // memory cannot be written while the sequencer is being cleared.
    assign load_ready_o  = reset_n && w_write_grant;
    assign mem_wen_o     = reset_n && w_write_grant;
    assign fetch_ready_o = reset_n && ((r_state == IDLE) || w_fetch_grant);

    // The memory address follows fetch whenever no write is granted so an
    // idle cycle still presents the fetch address to the RAM.
    assign mem_addr_o  = w_write_grant ? r_cur_addr : fetch_addr_i;
    assign mem_instr_o = load_data_i;

    // Read data comes straight from the RAM; it lines up with the registered
    // valid because the RAM has exactly one cycle of read latency.
    assign fetch_data_o       = mem_instr_i;
    assign fetch_data_valid_o = r_fetch_data_valid;
    assign load_busy_o        = r_load_busy;
    assign load_done_o        = r_load_done;

    // Burst sequencer. IDLE latches a new burst; LOAD walks the address,
    // counts down the remaining words and tracks the write run length. The
    // write that consumes the last word returns to IDLE and raises done for
    // one cycle. A zero-length start never enters LOAD but still reports done
    // so the host sees every start acknowledged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= IDLE;
            r_cur_addr         <= '0;
            r_remaining        <= '0;
            r_run_cnt          <= '0;
            r_load_busy        <= 1'b0;
            r_load_done        <= 1'b0;
            r_fetch_data_valid <= 1'b0;
        end else begin
            r_load_done        <= 1'b0;
            r_fetch_data_valid <= w_fetch_grant;
            case (r_state)
                IDLE: begin
                    if (load_start_i) begin
                        if (w_len_zero) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_state     <= LOAD;
                            r_cur_addr  <= load_addr_i;
                            r_remaining <= load_len_i;
                            r_run_cnt   <= '0;
                            r_load_busy <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_write_grant) begin
                        r_cur_addr  <= r_cur_addr + AW'(1);
                        r_remaining <= r_remaining - LW'(1);
                        r_run_cnt   <= w_run_cnt_next;
                        if (w_last_write) begin
                            r_state     <= IDLE;
                            r_load_busy <= 1'b0;
                            r_load_done <= 1'b1;
                        end
                    end else if (w_fetch_grant) begin
                        r_run_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single-port synchronous instruction memory (1-cycle read latency; a write cycle does not update read data).
- Shares the memory between the core fetch stage (reads) and a burst instruction loader (writes from the host/network side).
- Sequences auto-incrementing burst writes with a bounded write run, so fetch is never starved during a load.

Parameters:
- addr_width_p, 10: memory address width; depth = 2**addr_width_p.
- max_run_p, 4: max consecutive granted write cycles while fetch is pending; must be >= 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- load_start_i  in  1  burst start request; sampled only in IDLE.
- load_addr_i  in  addr_width_p  burst base address.
- load_len_i  in  addr_width_p+1  burst length in words, 0..2**addr_width_p.
- load_valid_i  in  1  load_data_i valid.
- load_data_i  in  instruction_s  instruction to write.
- load_ready_o  out  1  write accepted this cycle.
- load_busy_o  out  1  burst in progress.
- load_done_o  out  1  one-cycle pulse at burst completion.
- fetch_valid_i  in  1  fetch read request.
- fetch_addr_i  in  addr_width_p  fetch address.
- fetch_ready_o  out  1  fetch accepted this cycle.
- fetch_data_o  out  instruction_s  read data; equals mem_instr_i.
- fetch_data_valid_o  out  1  fetch_data_o valid; high the cycle after acceptance.
- mem_addr_o  out  addr_width_p  memory address.
- mem_instr_o  out  instruction_s  memory write data.
- mem_wen_o  out  1  memory write enable.
- mem_instr_i  in  instruction_s  memory read data.

Behaviour:
- State register and counters:
  - States: IDLE, LOAD.
  - cur_addr: addr_width_p bits.
  - remaining: addr_width_p+1 bits.
  - run_cnt: saturates at max_run_p.
- Reset (reset_n low, asynchronous):
  - Registers: state=IDLE, cur_addr=0, remaining=0, run_cnt=0.
  - Registered outputs: load_busy_o=0, load_done_o=0, fetch_data_valid_o=0.
  - Combinational outputs are forced low while reset_n is low: load_ready_o, fetch_ready_o, mem_wen_o.
  - Memory contents are untouched; a partially written burst stays partial.
- IDLE:
  - fetch_ready_o=1, load_ready_o=0, mem_wen_o=0, mem_addr_o=fetch_addr_i.
  - load_start_i with load_len_i!=0: latch cur_addr=load_addr_i, remaining=load_len_i, run_cnt=0; next state LOAD, load_busy_o=1 next cycle.
  - load_start_i with load_len_i==0: stay IDLE; load_done_o pulses next cycle.
- LOAD, grant decision each cycle (combinational):
  - Write grant when load_valid_i && (!fetch_valid_i || run_cnt<max_run_p).
  - Otherwise fetch grant when fetch_valid_i.
  - Otherwise no grant: mem_addr_o=fetch_addr_i, mem_wen_o=0.
- Write grant:
  - Outputs: load_ready_o=1, mem_wen_o=1, mem_addr_o=cur_addr, mem_instr_o=load_data_i.
  - cur_addr+1 wraps modulo 2**addr_width_p; remaining-1.
  - run_cnt+1 (saturating) if fetch_valid_i, else run_cnt=0.
- Fetch grant:
  - Outputs: fetch_ready_o=1, mem_addr_o=fetch_addr_i, mem_wen_o=0.
  - run_cnt=0.
- load_start_i during LOAD: ignored.
- load_start_i while load_valid_i is high in IDLE: no write occurs that cycle.
- Burst completion:
  - The write that takes remaining from 1 to 0 moves state to IDLE.
  - Next cycle: load_busy_o=0 and load_done_o=1, for exactly one cycle.
- Fetch response:
  - fetch_data_valid_o is registered, =1 in the cycle after any fetch grant (IDLE or LOAD).
  - fetch_data_o is a pass-through of mem_instr_i, meaningful only when fetch_data_valid_o=1.
  - Back-to-back fetches give a throughput of 1 per cycle.
- Fairness guarantee: with fetch_valid_i held high during LOAD, fetch waits at most max_run_p cycles.
- Write and fetch are never granted in the same cycle; exactly one of load_ready_o/fetch_ready_o may be high.

Test Plan:
- IDLE fetch: fetch_valid_i=1, addr 5 then 6 on consecutive cycles -> fetch_ready_o=1 both cycles; fetch_data_valid_o=1 one cycle later each; data=mem[5], mem[6].
- Burst, no fetch: start addr 8 len 4, load_valid_i continuous -> writes to 8,9,10,11 on 4 consecutive cycles; load_done_o pulses once the cycle after the 4th write; load_busy_o falls with it.
- Contention, max_run_p=2: load len 6, fetch_valid_i held high -> grant pattern W,W,F,W,W,F,W,W; fetch data valid each cycle after an F.
- Wrap and zero length: start addr 1022 len 4 -> writes 1022,1023,0,1; start with len 0 -> no write, load_done_o pulses, load_busy_o stays 0.
- Gaps: load_valid_i toggled 1,0,1,0 during a len 2 burst, no fetch -> load_ready_o only on valid cycles; addresses consecutive; done after 2nd write.
- Reset mid-load: reset_n low after 2 of 5 writes -> outputs low immediately; after release state is IDLE with fetch_ready_o=1; the 2 written words persist, and a new start works normally.
